// File: rtl/lm_wr_arb.sv
// rtl/lm_wr_arb.sv - round-robin burst arbiter for the local_mem write port
module lm_wr_arb #(
    parameter int AW        = 10,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic          CLK,
    input  logic          RESET_X,
    input  logic          SOFT_RESET,
    input  logic          R0_REQ,
    input  logic [AW-1:0] R0_ADR,
    input  logic [DW-1:0] R0_WDATA,
    input  logic          R0_LAST,
    output logic          R0_GNT,
    input  logic          R1_REQ,
    input  logic [AW-1:0] R1_ADR,
    input  logic [DW-1:0] R1_WDATA,
    input  logic          R1_LAST,
    output logic          R1_GNT,
    output logic          M_WR,
    output logic [AW-1:0] M_WADR,
    output logic [DW-1:0] M_WDATA,
    output logic [1:0]    OWNER,
    output logic          BUSY
);
    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            m_wr_q, m_wr_d;
    logic [AW-1:0]   m_wadr_q, m_wadr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;

    logic            owning, own1, own_req, own_last, oth_req, acc, rel;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_data;
    logic [CW-1:0]   cnt_now;

    always_comb begin
        owning   = (state_q == ST_OWN0) || (state_q == ST_OWN1);
        own1     = (state_q == ST_OWN1);
        own_req  = own1 ? R1_REQ   : R0_REQ;
        own_last = own1 ? R1_LAST  : R0_LAST;
        own_adr  = own1 ? R1_ADR   : R0_ADR;
        own_data = own1 ? R1_WDATA : R0_WDATA;
        oth_req  = own1 ? R0_REQ   : R1_REQ;
        acc      = owning && own_req;
        // count saturates so a lone owner can stream indefinitely
        cnt_now  = (acc && (cnt_q != MAX_CNT)) ? cnt_q + CW'(1) : cnt_q;
        rel      = owning && ((acc && own_last) || (oth_req && (cnt_now == MAX_CNT)));

        R0_GNT    = (state_q == ST_OWN0) && R0_REQ;
        R1_GNT    = (state_q == ST_OWN1) && R1_REQ;
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        m_wr_d    = acc;
        m_wadr_d  = acc ? own_adr  : m_wadr_q;
        m_wdata_d = acc ? own_data : m_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (R0_REQ && R1_REQ) begin
                    state_d = rr_q ? ST_OWN0 : ST_OWN1;
                end else if (R0_REQ) begin
                    state_d = ST_OWN0;
                end else if (R1_REQ) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                cnt_d = cnt_now;
                if (rel) begin
                    rr_d  = own1;
                    cnt_d = '0;
                    if (oth_req) begin
                        state_d = own1 ? ST_OWN0 : ST_OWN1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // soft reset also discards the beat accepted in this cycle
        if (SOFT_RESET) begin
            state_d   = ST_IDLE;
            rr_d      = 1'b1;
            cnt_d     = '0;
            m_wr_d    = 1'b0;
            m_wadr_d  = '0;
            m_wdata_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b1;
            cnt_q     <= '0;
            m_wr_q    <= 1'b0;
            m_wadr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            m_wr_q    <= m_wr_d;
            m_wadr_q  <= m_wadr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign M_WR    = m_wr_q;
    assign M_WADR  = m_wadr_q;
    assign M_WDATA = m_wdata_q;
    assign OWNER   = state_q;
    assign BUSY    = (state_q != ST_IDLE) || m_wr_q;

endmodule
